seq_mult_unsigned: RTL and testbench



---
 rtl/seq_mult_pkg.sv | 15 +
 rtl/seq_mult_unsigned.sv | 90 +++++++++
 tb/tb_seq_mult_unsigned.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter must hold WIDTH-1 with one bit of headroom.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_mult_unsigned.sv
// Iterative unsigned shift-add multiplier, one partial product per clock, valid/ready on both sides.
// Optional SEQ_MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_mult_unsigned
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplr;
  logic [CW-1:0]    cnt;

  logic [PW-1:0]    acc_nxt;
  logic             last;

  always_comb begin
    acc_nxt = mplr[0] ? acc + mcand : acc;
`ifdef SEQ_MULT_EARLY_TERM_EN
    last = (cnt == CW'(WIDTH - 1)) || (mplr[WIDTH-1:1] == '0);
`else
    last = (cnt == CW'(WIDTH - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= {{WIDTH{1'b0}}, a};
            mplr     <= b;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CW'(1);
          // product only moves here, so it is stable through DONE and IDLE
          if (last) begin
            product   <= acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_unsigned.sv
// Self-checking bench: WIDTH=8 and WIDTH=4 instances against a transaction-level countdown model.
module tb_seq_mult_unsigned;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  iv, ordy, ir, ov;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;
  logic [15:0] p8;
  logic [7:0]  p4;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  seq_mult_unsigned #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a8), .b(b8),
    .out_valid(ov[0]), .out_ready(ordy[0]), .product(p8));

  seq_mult_unsigned #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a4), .b(b4),
    .out_valid(ov[1]), .out_ready(ordy[1]), .product(p4));

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // cycles from input handshake to out_valid
  function automatic int exp_lat(input int w, input int unsigned bv);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int l = 1;
    for (int i = 0; i < w; i++) if (bv[i]) l = i + 1;
    return l;
`else
    return w;
`endif
  endfunction

  // model: 0 idle, 1 busy (countdown), 2 result held
  int     m_st   [2];
  int     m_left [2];
  longint m_res  [2];
  longint m_prod [2];
  bit     m_init = 1'b0;

  always @(posedge clk) begin
    if (rst) m_init <= 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_st[d] = 0; m_prod[d] = 0;
      end else if (m_st[d] == 0 && iv[d]) begin
        m_st[d]   = 1;
        m_left[d] = (d == 0) ? exp_lat(8, b8) : exp_lat(4, b4);
        m_res[d]  = (d == 0) ? longint'(a8) * longint'(b8) : longint'(a4) * longint'(b4);
      end else if (m_st[d] == 1) begin
        m_left[d]--;
        if (m_left[d] == 0) begin m_st[d] = 2; m_prod[d] = m_res[d]; end
      end else if (m_st[d] == 2 && ordy[d]) begin
        m_st[d] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      for (int d = 0; d < 2; d++) begin
        chk(d ? "in_ready4" : "in_ready8", longint'(ir[d]), longint'(m_st[d] == 0));
        chk(d ? "out_valid4" : "out_valid8", longint'(ov[d]), longint'(m_st[d] == 2));
        chk(d ? "product4" : "product8", d ? longint'(p4) : longint'(p8), m_prod[d]);
      end
    end
  end

  // Starts #1 after a posedge with the DUT idle; ends the same way after the output handshake.
  task automatic txn(input int d, input int unsigned av, input int unsigned bv, input int hold,
                     output int lat, output longint prod);
    if (d == 0) begin a8 = av[7:0]; b8 = bv[7:0]; end
    else begin a4 = av[3:0]; b4 = bv[3:0]; end
    iv[d] = 1'b1;
    @(posedge clk); #1 iv[d] = 1'b0;
    lat = 0;
    while (!ov[d] && lat < 200) begin @(posedge clk); #1 lat++; end
    if (!ov[d]) chk("out_valid_timeout", 0, 1);
    prod = d ? longint'(p4) : longint'(p8);
    for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
    if (hold > 0) chk("held_product", d ? longint'(p4) : longint'(p8), prod);
    ordy[d] = 1'b1;
    @(posedge clk); #1 ordy[d] = 1'b0;
  endtask

  initial begin
    int     lat;
    longint prod;
    int     cyc;
    int unsigned ra, rb;

    rst = 1'b1; iv = '0; ordy = '0; a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", longint'(ir[0]), 1);
    chk("reset_out_valid", longint'(ov[0]), 0);
    chk("reset_product", longint'(p8), 0);

    txn(0, 13, 11, 0, lat, prod);
    chk("13x11", prod, 143);
    chk("13x11_lat", lat, exp_lat(8, 11));
`ifndef SEQ_MULT_EARLY_TERM_EN
    chk("13x11_lat_lit", lat, 8);
`endif

    txn(0, 255, 255, 0, lat, prod);
    chk("255x255", prod, 65025);
    txn(1, 15, 15, 0, lat, prod);
    chk("15x15_w4", prod, 225);

    // backpressure then immediate re-accept
    txn(0, 200, 3, 5, lat, prod);
    chk("200x3", prod, 600);
    chk("ready_after_handshake", longint'(ir[0]), 1);
    txn(0, 0, 77, 0, lat, prod);
    chk("0x77", prod, 0);
    chk("0x77_lat", lat, exp_lat(8, 77));

    // reset on the third RUN edge
    a8 = 7; b8 = 9; iv[0] = 1'b1;
    @(posedge clk); #1 iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_out_valid", longint'(ov[0]), 0);
    chk("midrst_product", longint'(p8), 0);
    chk("midrst_in_ready", longint'(ir[0]), 1);
    txn(0, 7, 9, 0, lat, prod);
    chk("7x9", prod, 63);
    chk("7x9_lat", lat, exp_lat(8, 9));

    // in_valid chatter while busy must be dropped
    a8 = 6; b8 = 7; iv[0] = 1'b1;
    @(posedge clk); #1 a8 = 1; b8 = 1;
    cyc = 0;
    while (!ov[0] && cyc < 200) begin
      iv[0] = ~iv[0];
      @(posedge clk); #1 cyc++;
    end
    iv[0] = 1'b0;
    chk("6x7_ignored", longint'(p8), 42);
    ordy[0] = 1'b1;
    @(posedge clk); #1 ordy[0] = 1'b0;
    @(posedge clk); #1;
    chk("single_result", longint'(ov[0]), 0);

`ifdef SEQ_MULT_EARLY_TERM_EN
    txn(0, 77, 1, 0, lat, prod);
    chk("et_77x1", prod, 77);
    chk("et_77x1_lat", lat, 1);
    txn(0, 3, 16, 0, lat, prod);
    chk("et_3x16", prod, 48);
    chk("et_3x16_lat", lat, 5);
    txn(0, 99, 0, 0, lat, prod);
    chk("et_x0", prod, 0);
    chk("et_x0_lat", lat, 1);
`endif

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        txn(1, x, y, 0, lat, prod);
        chk("sweep4", prod, longint'(x * y));
        chk("sweep4_lat", lat, exp_lat(4, y));
      end

    for (int n = 0; n < 150; n++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      txn(0, ra, rb, $urandom_range(0, 3), lat, prod);
      chk("rand8", prod, longint'(ra) * longint'(rb));
      chk("rand8_lat", lat, exp_lat(8, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
